// File: rtl/axis_window_pkg.sv
// rtl/axis_window_pkg.sv - shared state type and default widths for the window placer
package axis_window_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    localparam int DEF_PIXEL_WIDTH = 8;
    localparam int DEF_IMG_WBITS   = 12;
    localparam int DEF_IMG_HBITS   = 12;

endpackage

// File: rtl/axis_window_pos_cnt.sv
// rtl/axis_window_pos_cnt.sv - output frame column/row position counter
//
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   clr                      frame start: return to (0,0)
//   adv                      advance one pixel (output load enable)
//   img_width, img_height    frame geometry (latched copy, never zero while counting)
//   col, row                 current pixel position
//   eol, eof                 current pixel is last of its line / last of the frame
module axis_window_pos_cnt
    import axis_window_pkg::*;
#(
    parameter int C_IMG_WBITS = DEF_IMG_WBITS,
    parameter int C_IMG_HBITS = DEF_IMG_HBITS
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clr,
    input  logic                   adv,
    input  logic [C_IMG_WBITS-1:0] img_width,
    input  logic [C_IMG_HBITS-1:0] img_height,
    output logic [C_IMG_WBITS-1:0] col,
    output logic [C_IMG_HBITS-1:0] row,
    output logic                   eol,
    output logic                   eof
);

    localparam logic [C_IMG_WBITS-1:0] ONE_W = {{(C_IMG_WBITS-1){1'b0}}, 1'b1};
    localparam logic [C_IMG_HBITS-1:0] ONE_H = {{(C_IMG_HBITS-1){1'b0}}, 1'b1};

    assign eol = (col == img_width - ONE_W);
    assign eof = eol && (row == img_height - ONE_H);

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (eol) begin
                col <= '0;
                row <= eof ? '0 : row + ONE_H;
            end else begin
                col <= col + ONE_W;
            end
        end
    end

endmodule

// File: rtl/axis_window_placer.sv
// rtl/axis_window_placer.sv - places a cropped window stream into a full background frame
//
// Ports:
//   clk, resetn                          clock, synchronous active-low reset
//   m_img_width, m_img_height            output frame size
//   s_win_left/top/width/height          window placement and size
//   bg_pixel                             fill value outside the window
//   s_axis_t*                            window stream in (tuser = SOF, tlast = EOL)
//   m_axis_t*                            full frame stream out (tuser = SOF, tlast = EOL)
//   err                                  one-cycle pulse on a window stream protocol violation
module axis_window_placer
    import axis_window_pkg::*;
#(
    parameter int C_PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int C_IMG_WBITS   = DEF_IMG_WBITS,
    parameter int C_IMG_HBITS   = DEF_IMG_HBITS
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [C_IMG_WBITS-1:0]   m_img_width,
    input  logic [C_IMG_HBITS-1:0]   m_img_height,
    input  logic [C_IMG_WBITS-1:0]   s_win_left,
    input  logic [C_IMG_HBITS-1:0]   s_win_top,
    input  logic [C_IMG_WBITS-1:0]   s_win_width,
    input  logic [C_IMG_HBITS-1:0]   s_win_height,
    input  logic [C_PIXEL_WIDTH-1:0] bg_pixel,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     err
);

    localparam int WX = C_IMG_WBITS + 1;
    localparam int HX = C_IMG_HBITS + 1;
    localparam logic [WX-1:0] ONE_WX = {{(WX-1){1'b0}}, 1'b1};
    localparam logic [HX-1:0] ONE_HX = {{(HX-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    // Configuration captured at SOF so mid-frame changes do not disturb the frame.
    logic [C_IMG_WBITS-1:0]   sh_wimg, sh_l, sh_w;
    logic [C_IMG_HBITS-1:0]   sh_himg, sh_t, sh_h;
    logic [C_PIXEL_WIDTH-1:0] sh_bg;

    logic win_dead;   // window empty/invalid or aborted: rest of frame is background
    logic win_done;   // every window pixel has been placed
    logic sof_owed;   // the SOF beat that opened this frame has not been taken yet

    logic [C_IMG_WBITS-1:0] col;
    logic [C_IMG_HBITS-1:0] row;
    logic                   eol, eof;

    logic [WX-1:0] col_x, l_x, lw_x;
    logic [HX-1:0] row_x, t_x, th_x;
    logic          in_win, at_origin, last_win_col, last_win_row;
    logic          cfg_zero, cfg_dead, out_free;

    logic                     s_ready, src_ok, ld, latch, sof_err, take_win;
    logic [C_PIXEL_WIDTH-1:0] pix;

    // Widened compares so L+W / T+H cannot wrap.
    assign col_x = {1'b0, col};
    assign row_x = {1'b0, row};
    assign l_x   = {1'b0, sh_l};
    assign t_x   = {1'b0, sh_t};
    assign lw_x  = {1'b0, sh_l} + {1'b0, sh_w};
    assign th_x  = {1'b0, sh_t} + {1'b0, sh_h};

    assign in_win       = (col_x >= l_x) && (col_x < lw_x) && (row_x >= t_x) && (row_x < th_x);
    assign at_origin    = (col == sh_l) && (row == sh_t);
    assign last_win_col = (col_x == lw_x - ONE_WX);
    assign last_win_row = (row_x == th_x - ONE_HX);

    assign cfg_zero = (m_img_width == '0) || (m_img_height == '0);
    assign cfg_dead = (s_win_width == '0) || (s_win_height == '0) ||
                      (({1'b0, s_win_left} + {1'b0, s_win_width}) > {1'b0, m_img_width}) ||
                      (({1'b0, s_win_top} + {1'b0, s_win_height}) > {1'b0, m_img_height});

    assign out_free = !m_axis_tvalid || m_axis_tready;

    always_comb begin
        state_d  = state_q;
        s_ready  = 1'b0;
        src_ok   = 1'b0;
        ld       = 1'b0;
        latch    = 1'b0;
        sof_err  = 1'b0;
        take_win = 1'b0;
        pix      = sh_bg;
        case (state_q)
            WAIT_SOF: begin
                // A SOF with a degenerate frame size is swallowed; a good one waits
                // here unconsumed until its window position comes round.
                s_ready = !s_axis_tuser || cfg_zero;
                if (s_axis_tvalid && s_axis_tuser && !cfg_zero) begin
                    latch   = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (in_win && !win_dead) begin
                    pix = s_axis_tdata;
                    if (s_axis_tvalid && s_axis_tuser && !at_origin) begin
                        // Early SOF belongs to the next frame: leave it on the bus.
                        sof_err = 1'b1;
                    end else begin
                        src_ok  = s_axis_tvalid;
                        s_ready = out_free;
                    end
                end else begin
                    src_ok = 1'b1;
                    if (win_done || win_dead) begin
                        s_ready = !s_axis_tuser || sof_owed;
                    end
                end
                ld       = out_free && src_ok;
                take_win = ld && in_win && !win_dead;
                if (ld && eof) begin
                    state_d = WAIT_SOF;
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    assign s_axis_tready = resetn && s_ready;

    axis_window_pos_cnt #(
        .C_IMG_WBITS (C_IMG_WBITS),
        .C_IMG_HBITS (C_IMG_HBITS)
    ) u_pos_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (latch),
        .adv        (ld),
        .img_width  (sh_wimg),
        .img_height (sh_himg),
        .col        (col),
        .row        (row),
        .eol        (eol),
        .eof        (eof)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= WAIT_SOF;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            err           <= 1'b0;
            win_dead      <= 1'b0;
            win_done      <= 1'b0;
            sof_owed      <= 1'b0;
            sh_wimg       <= '0;
            sh_himg       <= '0;
            sh_l          <= '0;
            sh_t          <= '0;
            sh_w          <= '0;
            sh_h          <= '0;
            sh_bg         <= '0;
        end else begin
            state_q <= state_d;
            err     <= sof_err || (take_win && (s_axis_tlast != last_win_col));

            if (latch) begin
                sh_wimg  <= m_img_width;
                sh_himg  <= m_img_height;
                sh_l     <= s_win_left;
                sh_t     <= s_win_top;
                sh_w     <= s_win_width;
                sh_h     <= s_win_height;
                sh_bg    <= bg_pixel;
                win_dead <= cfg_dead;
                win_done <= 1'b0;
                sof_owed <= 1'b1;
            end else begin
                if (sof_err) begin
                    win_dead <= 1'b1;
                end
                if (take_win && last_win_col && last_win_row) begin
                    win_done <= 1'b1;
                end
                if ((state_q == ACTIVE) && s_axis_tvalid && s_ready) begin
                    sof_owed <= 1'b0;
                end
            end

            if (ld) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= pix;
                m_axis_tuser  <= (col == '0) && (row == '0);
                m_axis_tlast  <= eol;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_window_placer.sv
// tb/tb_axis_window_placer.sv - self-checking bench for axis_window_placer
module tb_axis_window_placer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] m_img_width, s_win_left, s_win_width;
    logic [11:0] m_img_height, s_win_top, s_win_height;
    logic [7:0]  bg_pixel;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
    logic [7:0]  s_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
    logic [7:0]  m_axis_tdata;
    logic        err;

    always #5 clk = ~clk;

    axis_window_placer #(
        .C_PIXEL_WIDTH (8),
        .C_IMG_WBITS   (12),
        .C_IMG_HBITS   (12)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .m_img_width   (m_img_width),
        .m_img_height  (m_img_height),
        .s_win_left    (s_win_left),
        .s_win_top     (s_win_top),
        .s_win_width   (s_win_width),
        .s_win_height  (s_win_height),
        .bg_pixel      (bg_pixel),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .err           (err)
    );

    typedef struct {
        int wimg; int himg; int l; int t; int w; int h;
        int stall; int nsrc; bit dead;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       u;
        logic       l;
    } beat_t;

    beat_t      src_q[$];
    beat_t      out_q[$];
    beat_t      exp_q[$];
    logic [7:0] win_d[$];

    int    checks = 0;
    int    errors = 0;
    int    err_cnt = 0;
    int    stall = 0;
    bit    taken = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t pv;
    beat_t nb;

    function automatic int pk(input beat_t b);
        return int'({b.d, b.u, b.l});
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Source and sink: drive at negedge, observe the coming handshakes 1 ns later.
    initial begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        forever begin
            @(negedge clk);
            if (taken) begin
                s_axis_tvalid = 1'b0;
                taken = 1'b0;
            end
            if (!s_axis_tvalid && src_q.size() > 0 && int'($urandom_range(99)) >= stall) begin
                nb = src_q.pop_front();
                s_axis_tdata  = nb.d;
                s_axis_tuser  = nb.u;
                s_axis_tlast  = nb.l;
                s_axis_tvalid = 1'b1;
            end
            m_axis_tready = (int'($urandom_range(99)) >= stall);
            #1;
            if (!resetn) begin
                s_axis_tvalid = 1'b0;
                taken = 1'b0;
                src_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("hold", int'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}),
                          int'({1'b1, pv.d, pv.u, pv.l}));
                if (m_axis_tvalid && m_axis_tready)
                    out_q.push_back('{m_axis_tdata, m_axis_tuser, m_axis_tlast});
                if (s_axis_tvalid && s_axis_tready) taken = 1'b1;
                if (err) err_cnt++;
                prev_stall = m_axis_tvalid && !m_axis_tready;
                pv = '{m_axis_tdata, m_axis_tuser, m_axis_tlast};
            end
        end
    end

    task automatic apply_cfg(input vec_t v, input logic [7:0] bg);
        m_img_width  = 12'(v.wimg);
        m_img_height = 12'(v.himg);
        s_win_left   = 12'(v.l);
        s_win_top    = 12'(v.t);
        s_win_width  = 12'(v.w);
        s_win_height = 12'(v.h);
        bg_pixel     = bg;
    endtask

    // Reference frame: raster scan, window pixels taken in order from win_d,
    // only the first nwin window positions carry data, everything else is bg.
    task automatic model(input vec_t v, input logic [7:0] bg, input int nwin, input bit dead);
        int k = 0;
        beat_t b;
        for (int r = 0; r < v.himg; r++) begin
            for (int c = 0; c < v.wimg; c++) begin
                b.d = bg;
                if (!dead && c >= v.l && c < v.l + v.w && r >= v.t && r < v.t + v.h) begin
                    if (k < nwin) b.d = win_d[k];
                    k++;
                end
                b.u = (r == 0 && c == 0);
                b.l = (c == v.wimg - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic push_src(input vec_t v, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = (i < win_d.size()) ? win_d[i] : 8'(i + 8'h60);
            b.u = (i == 0);
            b.l = (v.w > 0) ? ((i % v.w) == v.w - 1) : 1'b0;
            src_q.push_back(b);
        end
    endtask

    task automatic run_check(input string name, input int err_before, input int err_want);
        int budget = 0;
        while (!(src_q.size() == 0 && !s_axis_tvalid && out_q.size() >= exp_q.size()) && budget < 4000) begin
            @(negedge clk); #3;
            budget++;
        end
        if (budget >= 4000) check({name, " timeout"}, budget, 0);
        repeat (4) @(negedge clk);
        #3;
        check({name, " count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s beat %0d", name, i), pk(out_q[i]), pk(exp_q[i]));
        check({name, " err"}, err_cnt - err_before, err_want);
        out_q.delete();
        exp_q.delete();
    endtask

    vec_t tbl[8];
    vec_t v;
    int   e0;
    int   n;

    initial begin
        tbl[0] = '{8, 4, 2, 1, 3, 2,  0, 0, 1'b0};   // basic placement
        tbl[1] = '{8, 4, 2, 1, 3, 2, 50, 0, 1'b0};   // stalls both sides
        tbl[2] = '{8, 4, 2, 1, 0, 2,  0, 6, 1'b1};   // W=0, 6 beats drained
        tbl[3] = '{8, 4, 6, 1, 3, 2,  0, 0, 1'b1};   // L+W past right edge
        tbl[4] = '{8, 4, 5, 2, 3, 2,  0, 0, 1'b0};   // window touching right/bottom edge
        tbl[5] = '{8, 4, 0, 0, 8, 4, 30, 0, 1'b0};   // window is the whole frame
        tbl[6] = '{0, 4, 2, 1, 3, 2,  0, 0, 1'b0};   // zero-width frame: no output
        tbl[7] = '{8, 4, 1, 3, 2, 2,  0, 0, 1'b1};   // T+H past bottom edge

        resetn = 1'b0;
        apply_cfg(tbl[0], 8'hAA);
        repeat (3) @(negedge clk);
        #2;
        check("rst s_tready", s_axis_tready, 0);
        check("rst m_tvalid", m_axis_tvalid, 0);
        check("rst m_tdata",  m_axis_tdata, 0);
        check("rst m_tuser",  m_axis_tuser, 0);
        check("rst m_tlast",  m_axis_tlast, 0);
        check("rst err",      err, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        #3;

        for (int k = 0; k < 8; k++) begin
            e0 = err_cnt;
            stall = tbl[k].stall;
            apply_cfg(tbl[k], 8'hAA);
            win_d.delete();
            for (int i = 0; i < tbl[k].w * tbl[k].h; i++) win_d.push_back(8'(i + 1));
            n = (tbl[k].nsrc != 0) ? tbl[k].nsrc : ((tbl[k].w * tbl[k].h > 0) ? tbl[k].w * tbl[k].h : 1);
            model(tbl[k], 8'hAA, tbl[k].w * tbl[k].h, tbl[k].dead);
            push_src(tbl[k], n);
            run_check($sformatf("vec%0d", k), e0, 0);
        end

        for (int k = 0; k < 6; k++) begin
            logic [7:0] bg;
            v.wimg = $urandom_range(10, 1);
            v.himg = $urandom_range(5, 1);
            v.l = $urandom_range(v.wimg, 0);
            v.w = $urandom_range(v.wimg, 0);
            v.t = $urandom_range(v.himg, 0);
            v.h = $urandom_range(v.himg, 0);
            v.stall = $urandom_range(60, 0);
            v.nsrc = 0;
            v.dead = (v.w == 0) || (v.h == 0) || (v.l + v.w > v.wimg) || (v.t + v.h > v.himg);
            bg = 8'($urandom);
            e0 = err_cnt;
            stall = v.stall;
            apply_cfg(v, bg);
            win_d.delete();
            for (int i = 0; i < v.w * v.h; i++) win_d.push_back(8'($urandom));
            model(v, bg, v.w * v.h, v.dead);
            push_src(v, (v.w * v.h > 0) ? v.w * v.h : 1);
            run_check($sformatf("rnd%0d", k), e0, 0);
        end

        // Early SOF on the 4th window beat: frame ends in bg, that beat opens the next frame.
        stall = 0;
        e0 = err_cnt;
        apply_cfg(tbl[0], 8'hAA);
        win_d = '{8'h01, 8'h02, 8'h03};
        model(tbl[0], 8'hAA, 3, 1'b0);
        win_d = '{8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
        model(tbl[0], 8'hAA, 6, 1'b0);
        src_q.push_back('{8'h01, 1'b1, 1'b0});
        src_q.push_back('{8'h02, 1'b0, 1'b0});
        src_q.push_back('{8'h03, 1'b0, 1'b1});
        push_src(tbl[0], 6);
        run_check("presof", e0, 1);

        // Wrong tlast on a window beat: err pulses, data still placed.
        e0 = err_cnt;
        win_d = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        model(tbl[0], 8'hAA, 6, 1'b0);
        push_src(tbl[0], 6);
        src_q[1].l = 1'b1;
        run_check("badlast", e0, 1);

        // Reset in the middle of row 2, then a fresh frame after some stray beats.
        win_d = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        push_src(tbl[0], 6);
        n = 0;
        while (out_q.size() < 20 && n < 500) begin
            @(negedge clk); #3;
            n++;
        end
        check("midrow reached", (out_q.size() >= 20) ? 1 : 0, 1);
        @(negedge clk);
        resetn = 1'b0;
        #2;
        check("mid rst s_tready", s_axis_tready, 0);
        @(negedge clk);
        resetn = 1'b1;
        #2;
        check("mid rst m_tvalid", m_axis_tvalid, 0);
        check("mid rst m_tdata",  m_axis_tdata, 0);
        check("mid rst m_tuser",  m_axis_tuser, 0);
        check("mid rst m_tlast",  m_axis_tlast, 0);
        check("mid rst err",      err, 0);
        out_q.delete();
        e0 = err_cnt;
        src_q.push_back('{8'h77, 1'b0, 1'b0});
        src_q.push_back('{8'h78, 1'b0, 1'b1});
        win_d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        model(tbl[0], 8'hAA, 6, 1'b0);
        push_src(tbl[0], 6);
        run_check("after_rst", e0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_window_placer.md
Name: axis_window_placer

Overview:
- Inverse of the window crop path: takes a cropped window as an AXI4-Stream (tuser = SOF, tlast = EOL) and emits a full-size frame.
- The window sits at (s_win_left, s_win_top); every other pixel is the constant bg_pixel.
- Sits downstream of window processing, before display or VDMA writers, so cropped results return to full-frame geometry.

Parameters:
- C_PIXEL_WIDTH, 8, pixel/tdata width.
- C_IMG_WBITS, 12, width of column counters and horizontal config.
- C_IMG_HBITS, 12, width of row counters and vertical config.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- m_img_width  in  C_IMG_WBITS  output frame width.
- m_img_height  in  C_IMG_HBITS  output frame height.
- s_win_left  in  C_IMG_WBITS  window x offset.
- s_win_top  in  C_IMG_HBITS  window y offset.
- s_win_width  in  C_IMG_WBITS  window width.
- s_win_height  in  C_IMG_HBITS  window height.
- bg_pixel  in  C_PIXEL_WIDTH  fill value.
- s_axis_tvalid/tready/tuser/tlast  in/out/in/in  1  window stream control.
- s_axis_tdata  in  C_PIXEL_WIDTH  window pixel.
- m_axis_tvalid/tready/tuser/tlast  out/in/out/out  1  frame stream control.
- m_axis_tdata  out  C_PIXEL_WIDTH  frame pixel.
- err  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset (resetn=0 at posedge): state=WAIT_SOF; m_axis_tvalid/tdata/tuser/tlast=0; err=0; counters=0. s_axis_tready=0 whenever resetn=0. Reset mid-frame aborts the frame immediately with no tail beats.
- Registered output stage. Load enable ld = (!m_axis_tvalid || m_axis_tready) && src_ok. Latency from input handshake to m_axis_tvalid is 1 cycle. Full throughput: 1 pixel/clk when ready.
- States:
  - WAIT_SOF: s_axis_tready = !s_axis_tuser. Non-SOF beats are dropped. On s_axis_tvalid && s_axis_tuser, latch all config into shadow registers, clear col/row, go ACTIVE. The SOF beat is not consumed here.
  - ACTIVE: emits pixel (col,row).
    - in_win = col>=L && col<L+W && row>=T && row<T+H, using shadow values and C_IMG_WBITS+1 / C_IMG_HBITS+1 bit compares with no wrap.
    - If in_win and !win_dead: src_ok=s_axis_tvalid; s_axis_tready = (!m_axis_tvalid || m_axis_tready); data=s_axis_tdata.
    - Otherwise: src_ok=1; data=bg_pixel.
    - If win_done or win_dead: s_axis_tready=1 for non-SOF beats, which are dropped.
    - Flags: tuser=(col==0 && row==0), tlast=(col==Wimg-1). On ld, col increments; at Wimg-1, col=0 and row++.
    - When the beat (Wimg-1,Himg-1) is loaded, go WAIT_SOF.
- win_done: set once W*H window beats have been consumed (last window position loaded).
- win_dead is set at the latch point when W==0, H==0, L+W>Wimg, or T+H>Himg. In that case the window is empty: all-bg frame, and input is drained until the next SOF.
- Protocol checks on consumed in-window beats:
  - tuser=1 at a position other than (L,T): the beat is not consumed, err pulses, win_dead is set, and the rest of the frame is bg. The next frame starts from WAIT_SOF on that beat.
  - tlast != (col==L+W-1): err pulses, data is used anyway.
- Wimg==0 or Himg==0 at the latch point: stay in WAIT_SOF, consume and drop the SOF beat.
- Config changes mid-frame have no effect until the next latch.
- Backpressure: m_axis_tdata/tuser/tlast stay stable while m_axis_tvalid && !m_axis_tready.

Decomposition:
- Shared package axis_window_pkg: state enum (WAIT_SOF, ACTIVE) and the config bundle width constants.
- One sub-module, axis_window_pos_cnt: col/row counters with the end-of-line and end-of-frame flags, advanced by the load enable and cleared at frame start.

Test Plan:
- Wimg=8, Himg=4, window L=2,T=1,W=3,H=2, data 1..6, m_ready=1 -> 32 beats; rows 1–2 cols 2–4 = 1..6, rest bg=0xAA; tuser only on beat 0, tlast on beats 7,15,23,31.
- Same config, m_axis_tready toggling 50% random and s_axis_tvalid gaps -> identical beat sequence, no data change while stalled, no beat lost.
- W=0 -> all-bg 32-beat frame; 6 input beats after SOF are drained; next SOF starts a new frame.
- L=6,W=3 (exceeds 8) -> win_dead; all-bg frame; err stays 0.
- Premature SOF at the 4th window beat -> err pulse; remaining frame is bg; next frame's first output pixel (L,T) equals that SOF beat's data.
- resetn low for 1 cycle mid-row 2 -> all outputs 0 next cycle; resumes only after a fresh SOF, output starting at (0,0).
